// File: rtl/decoder_scan_ctrl.sv
// Round-robin scan sequencer for a 74x139-style 2-to-4 decoder.
// Visits unmasked outputs with a break-before-make blanking gap and a programmable dwell.
module decoder_scan_ctrl #(
   parameter int unsigned DWELL_W   = 16,
   parameter int unsigned BLANK_CYC = 2
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               EN,
   input  logic [DWELL_W-1:0] DWELL,
   input  logic [3:0]         MASK,
   output logic               G,
   output logic               A,
   output logic               B,
   output logic [1:0]         IDX,
   output logic               FRAME,
   output logic               BUSY
);

   localparam int unsigned BLANK_N = (BLANK_CYC < 1) ? 1 : BLANK_CYC;
   localparam int unsigned BLANK_W = (BLANK_N < 2) ? 1 : $clog2(BLANK_N);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BLANK  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 g_q, g_d;
   logic [1:0]           sel_q, sel_d;
   logic                 frame_q, frame_d;
   logic                 busy_q, busy_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic [BLANK_W-1:0]   blank_q, blank_d;
   logic [1:0]           nxt_c;

   // Lowest set bit of the mask; caller guarantees the mask is non-zero.
   function automatic logic [1:0] first_idx(input logic [3:0] mask);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i]) r = 2'(i);
      end
      return r;
   endfunction

   // Cyclic search from cur+1; cur itself is the fallback candidate.
   function automatic logic [1:0] next_idx(input logic [1:0] cur, input logic [3:0] mask);
      logic [1:0] r;
      logic [1:0] cand;
      r = cur;
      for (int k = 3; k >= 1; k--) begin
         cand = cur + 2'(k);
         if (mask[cand]) r = cand;
      end
      return r;
   endfunction

   assign nxt_c = next_idx(sel_q, MASK);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         g_q     <= 1'b1;
         sel_q   <= 2'd0;
         frame_q <= 1'b0;
         busy_q  <= 1'b0;
         dwell_q <= '0;
         blank_q <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         sel_q   <= sel_d;
         frame_q <= frame_d;
         busy_q  <= busy_d;
         dwell_q <= dwell_d;
         blank_q <= blank_d;
      end
   end

   // Next state and next registered outputs; G defaults high so every exit blanks.
   always_comb begin
      state_d = state_q;
      g_d     = 1'b1;
      sel_d   = sel_q;
      frame_d = 1'b0;
      dwell_d = dwell_q;
      blank_d = blank_q;

      unique case (state_q)
         IDLE: begin
            if (EN && (MASK != 4'd0)) begin
               sel_d   = first_idx(MASK);
               blank_d = '0;
               state_d = BLANK;
            end
         end

         BLANK: begin
            if (!EN) begin
               state_d = IDLE;
            end else if (blank_q == BLANK_W'(BLANK_N - 1)) begin
               state_d = ACTIVE;
               g_d     = 1'b0;
               dwell_d = (DWELL == '0) ? DWELL_W'(1) : DWELL;
            end else begin
               blank_d = blank_q + BLANK_W'(1);
            end
         end

         ACTIVE: begin
            if (!EN) begin
               state_d = IDLE;
               dwell_d = '0;
            end else if (dwell_q <= DWELL_W'(1)) begin
               dwell_d = '0;
               if (MASK != 4'd0) begin
                  sel_d   = nxt_c;
                  frame_d = (nxt_c <= sel_q);
                  blank_d = '0;
                  state_d = BLANK;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               g_d     = 1'b0;
               dwell_d = dwell_q - DWELL_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign G     = g_q;
   assign A     = sel_q[0];
   assign B     = sel_q[1];
   assign IDX   = sel_q;
   assign FRAME = frame_q;
   assign BUSY  = busy_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: directed scenarios plus random traffic, compared every
// cycle against a slot-position model of the scan.
module tb_decoder_scan_ctrl;

   localparam int unsigned DWELL_W   = 16;
   localparam int unsigned BLANK_CYC = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic               en;
   logic [DWELL_W-1:0] dwell;
   logic [3:0]         mask;
   logic               g, a, b, frame, busy;
   logic [1:0]         idx;

   decoder_scan_ctrl #(.DWELL_W(DWELL_W), .BLANK_CYC(BLANK_CYC)) dut (
      .CLK   (clk),
      .RESET (reset),
      .EN    (en),
      .DWELL (dwell),
      .MASK  (mask),
      .G     (g),
      .A     (a),
      .B     (b),
      .IDX   (idx),
      .FRAME (frame),
      .BUSY  (busy)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   string phase = "init";

   // Model: a slot is BLANK_CYC blank cycles followed by the latched dwell.
   bit m_run   = 1'b0;
   int m_idx   = 0;
   int m_pos   = 0;
   int m_dw    = 1;
   bit m_frame = 1'b0;

   int frame_cnt = 0;
   int glow_cnt  = 0;

   function automatic int lowest(input logic [3:0] m);
      for (int i = 0; i < 4; i++) if (m[i]) return i;
      return 0;
   endfunction

   function automatic int next_of(input int cur, input logic [3:0] m);
      for (int k = 1; k <= 4; k++) if (m[(cur + k) % 4]) return (cur + k) % 4;
      return cur;
   endfunction

   task automatic model_edge();
      int nx;
      m_frame = 1'b0;
      if (reset) begin
         m_run = 1'b0;
         m_idx = 0;
         m_pos = 0;
      end else if (!m_run) begin
         if (en && mask != 4'd0) begin
            m_run = 1'b1;
            m_idx = lowest(mask);
            m_pos = 0;
         end
      end else if (!en) begin
         m_run = 1'b0;
      end else begin
         m_pos++;
         if (m_pos == int'(BLANK_CYC)) m_dw = (dwell == '0) ? 1 : int'(dwell);
         if (m_pos == int'(BLANK_CYC) + m_dw) begin
            if (mask != 4'd0) begin
               nx      = next_of(m_idx, mask);
               m_frame = (nx <= m_idx);
               m_idx   = nx;
               m_pos   = 0;
            end else begin
               m_run = 1'b0;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic exp_g;
      exp_g = !(m_run && m_pos >= int'(BLANK_CYC));
      chk({phase, ".G"},     32'(g),     32'(exp_g));
      chk({phase, ".A"},     32'(a),     32'(m_idx & 1));
      chk({phase, ".B"},     32'(b),     32'((m_idx >> 1) & 1));
      chk({phase, ".IDX"},   32'(idx),   32'(m_idx));
      chk({phase, ".FRAME"}, 32'(frame), 32'(m_frame));
      chk({phase, ".BUSY"},  32'(busy),  32'(m_run));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      if (frame === 1'b1) frame_cnt++;
      if (g === 1'b0) glow_cnt++;
      check_model();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      reset = 1'b1;
      en    = 1'b1;
      mask  = 4'hF;
      dwell = DWELL_W'(3);

      phase = "reset";
      steps(2);
      chk("reset.G",     32'(g),     32'd1);
      chk("reset.IDX",   32'(idx),   32'd0);
      chk("reset.FRAME", 32'(frame), 32'd0);
      chk("reset.BUSY",  32'(busy),  32'd0);
      reset = 1'b0;
      #1;
      chk("reset_rel.G",    32'(g),    32'd1);
      chk("reset_rel.BUSY", 32'(busy), 32'd0);

      phase = "full_scan";
      step();
      chk("full_start.BUSY", 32'(busy), 32'd1);
      chk("full_start.IDX",  32'(idx),  32'd0);
      frame_cnt = 0;
      glow_cnt  = 0;
      steps(40);
      chk("full.frames", 32'(frame_cnt), 32'd2);
      chk("full.glow",   32'(glow_cnt),  32'd24);

      phase = "idle";
      en = 1'b0;
      steps(3);
      phase = "sparse";
      mask  = 4'b1010;
      dwell = DWELL_W'(4);
      en    = 1'b1;
      step();
      chk("sparse_start.IDX", 32'(idx), 32'd1);
      frame_cnt = 0;
      glow_cnt  = 0;
      steps(36);
      chk("sparse.frames", 32'(frame_cnt), 32'd3);
      chk("sparse.glow",   32'(glow_cnt),  32'd24);

      phase = "idle";
      en = 1'b0;
      steps(3);
      phase = "single";
      mask  = 4'b0100;
      dwell = '0;
      en    = 1'b1;
      step();
      frame_cnt = 0;
      glow_cnt  = 0;
      steps(30);
      chk("single.frames", 32'(frame_cnt), 32'd10);
      chk("single.glow",   32'(glow_cnt),  32'd10);
      chk("single.IDX",    32'(idx),       32'd2);

      phase = "idle";
      en = 1'b0;
      steps(3);
      phase = "abort";
      mask  = 4'b0010;
      dwell = DWELL_W'(5);
      en    = 1'b1;
      steps(4);
      chk("abort_pre.G", 32'(g), 32'd0);
      en = 1'b0;
      step();
      chk("abort.G",     32'(g),     32'd1);
      chk("abort.BUSY",  32'(busy),  32'd0);
      chk("abort.IDX",   32'(idx),   32'd1);
      chk("abort.FRAME", 32'(frame), 32'd0);
      mask = 4'b1011;
      en   = 1'b1;
      step();
      chk("restart.IDX",  32'(idx),  32'd0);
      chk("restart.BUSY", 32'(busy), 32'd1);

      phase = "idle";
      en = 1'b0;
      steps(3);
      phase = "empty";
      mask = 4'b0000;
      en   = 1'b1;
      steps(20);
      chk("empty.G",    32'(g),    32'd1);
      chk("empty.BUSY", 32'(busy), 32'd0);
      mask = 4'b1000;
      step();
      chk("empty_set.IDX", 32'(idx), 32'd3);
      chk("empty_set.G",   32'(g),   32'd1);
      steps(2);
      chk("empty_set.G_low", 32'(g), 32'd0);

      phase = "idle";
      en = 1'b0;
      steps(3);
      phase = "long_dwell";
      mask  = 4'b0001;
      dwell = DWELL_W'(300);
      en    = 1'b1;
      step();
      frame_cnt = 0;
      glow_cnt  = 0;
      steps(302);
      chk("long.glow",   32'(glow_cnt),  32'd300);
      chk("long.frames", 32'(frame_cnt), 32'd1);

      phase = "random";
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 99) < 3)   en    = ~en;
         if ($urandom_range(0, 99) < 4)   mask  = 4'($urandom);
         if ($urandom_range(0, 99) < 5)   dwell = DWELL_W'($urandom_range(0, 6));
         reset = ($urandom_range(0, 399) == 0);
         step();
      end
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
